// File: rtl/wb_spi_master_mc.sv
// Wishbone-slave SPI master: configurable width, NUM_SS selects, CPOL/CPHA modes, LSB/MSB first.
// Latency: bus ack 1 cycle after strobe; busy rise to DONE = (2*DATA_W+2)*(DIV+1) clk cycles.
// Backpressure: none on the bus (every strobe acked next cycle); DATA writes while busy are dropped and flag OVR.
//
// Ports: clk/rst (sync, active-high); wb_* Wishbone slave (wb_dout = write data in, wb_din = read data out);
//        spi_sck/spi_mosi/spi_miso/spi_ss (active-low selects); irq = DONE & IEN, level.
// Map:   0x00 CTRL {SS_SEL[8+:SS_W], HOLD_SS, IEN, LSB_FIRST, CPHA, CPOL}
//        0x04 STATUS {OVR(w1c), DONE(w1c), BUSY}; 0x10 DATA; 0x20 DIV.
module wb_spi_master_mc #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       wb_addr,
    input  logic              wb_we,
    input  logic              wb_stb,
    input  logic              wb_cyc,
    input  logic [31:0]       wb_dout,
    output logic [31:0]       wb_din,
    output logic              wb_ack,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_SS-1:0] spi_ss,
    output logic              irq
);
    localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
    localparam int HP_W = $clog2(2 * DATA_W);
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(2 * DATA_W - 1);
    localparam logic [HP_W-1:0] HP_PEN  = HP_W'(2 * DATA_W - 2);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

    state_t             state_q;
    logic               cpol_q, cpha_q, lsb_q, ien_q, hold_q;
    logic [SS_W-1:0]    sel_q;
    logic [DIV_W-1:0]   div_q;
    logic               done_q, ovr_q;
    logic [DATA_W-1:0]  rx_q;
    // Per-transfer snapshot so CTRL/DIV writes during a transfer only affect the next one.
    logic               cpol_s_q, cpha_s_q, lsb_s_q, hold_s_q;
    logic [DIV_W-1:0]   div_s_q;
    logic [DIV_W-1:0]   cnt_q;
    logic [HP_W-1:0]    hp_q;
    logic [DATA_W-1:0]  tx_q, rsh_q;
    logic               held_q;
    logic               wb_ack_q, sck_q, mosi_q, irq_q;
    logic [31:0]        wb_din_q;
    logic [NUM_SS-1:0]  ss_q;

    logic               acc, wr, rd, busy, start;
    logic               wr_ctrl, wr_stat, wr_data, wr_div, rd_data;
    logic               hold_d, ien_d, done_d, ovr_d, irq_d, half_end, done_set;
    logic [7:0]         adr;
    logic [31:0]        rdata;
    logic               unused_bits;

    assign unused_bits = ^{wb_addr[31:8], wb_dout};

    assign acc     = wb_stb & wb_cyc & ~wb_ack_q;
    assign wr      = acc & wb_we;
    assign rd      = acc & ~wb_we;
    assign adr     = wb_addr[7:0];
    assign busy    = (state_q != S_IDLE);
    assign wr_ctrl = wr && (adr == 8'h00);
    assign wr_stat = wr && (adr == 8'h04);
    assign wr_data = wr && (adr == 8'h10);
    assign wr_div  = wr && (adr == 8'h20);
    assign rd_data = rd && (adr == 8'h10);
    assign start   = wr_data && !busy;

    assign half_end = (cnt_q == div_s_q);
    assign done_set = (state_q == S_HOLD) && half_end;
    assign hold_d   = wr_ctrl ? wb_dout[4] : hold_q;
    assign ien_d    = wr_ctrl ? wb_dout[3] : ien_q;
    // A DONE set on the same edge as its clear (W1C or DATA read) wins.
    assign done_d   = done_set | (done_q & ~((wr_stat & wb_dout[1]) | rd_data));
    assign ovr_d    = (wr_data & busy) | (ovr_q & ~(wr_stat & wb_dout[2]));
    assign irq_d    = done_d & ien_d;

    always_comb begin
        rdata = '0;
        case (adr)
            8'h00: begin
                rdata[4:0]       = {hold_q, ien_q, lsb_q, cpha_q, cpol_q};
                rdata[8 +: SS_W] = sel_q;
            end
            8'h04:   rdata[2:0]        = {ovr_q, done_q, busy};
            8'h10:   rdata[DATA_W-1:0] = rx_q;
            8'h20:   rdata[DIV_W-1:0]  = div_q;
            default: rdata = '0;
        endcase
    end

    function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] r, input logic lsb,
                                                   input logic b);
        return lsb ? {b, r[DATA_W-1:1]} : {r[DATA_W-2:0], b};
    endfunction

    // Selects at or beyond NUM_SS match no line, so every select stays high.
    function automatic logic [NUM_SS-1:0] ss_onehot_n(input logic [SS_W-1:0] sel);
        logic [NUM_SS-1:0] r;
        r = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (sel == SS_W'(i)) r[i] = 1'b0;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cpol_q   <= 1'b0; cpha_q <= 1'b0; lsb_q <= 1'b0; ien_q <= 1'b0; hold_q <= 1'b0;
            sel_q    <= '0;
            div_q    <= '0;
            done_q   <= 1'b0; ovr_q <= 1'b0; irq_q <= 1'b0;
            rx_q     <= '0;
            cpol_s_q <= 1'b0; cpha_s_q <= 1'b0; lsb_s_q <= 1'b0; hold_s_q <= 1'b0;
            div_s_q  <= '0;
            cnt_q    <= '0;
            hp_q     <= '0;
            tx_q     <= '0;
            rsh_q    <= '0;
            held_q   <= 1'b0;
            wb_ack_q <= 1'b0;
            wb_din_q <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            ss_q     <= '1;
        end else begin
            wb_ack_q <= acc;
            if (acc) wb_din_q <= rdata;
            if (wr_ctrl) begin
                cpol_q <= wb_dout[0];
                cpha_q <= wb_dout[1];
                lsb_q  <= wb_dout[2];
                ien_q  <= wb_dout[3];
                hold_q <= wb_dout[4];
                sel_q  <= wb_dout[8 +: SS_W];
            end
            if (wr_div) div_q <= wb_dout[DIV_W-1:0];
            done_q <= done_d;
            ovr_q  <= ovr_d;
            irq_q  <= irq_d;

            case (state_q)
                S_IDLE: begin
                    sck_q <= cpol_q;
                    // A select left held by the previous transfer drops as soon as HOLD_SS clears.
                    if (held_q && !hold_d) begin
                        ss_q   <= '1;
                        held_q <= 1'b0;
                    end
                    if (start) begin
                        state_q  <= S_SETUP;
                        cnt_q    <= '0;
                        hp_q     <= '0;
                        cpol_s_q <= cpol_q;
                        cpha_s_q <= cpha_q;
                        lsb_s_q  <= lsb_q;
                        hold_s_q <= hold_q;
                        div_s_q  <= div_q;
                        rsh_q    <= '0;
                        ss_q     <= ss_onehot_n(sel_q);
                        held_q   <= 1'b0;
                        if (!cpha_q) begin
                            mosi_q <= first_bit(wb_dout[DATA_W-1:0], lsb_q);
                            tx_q   <= shift_out(wb_dout[DATA_W-1:0], lsb_q);
                        end else begin
                            tx_q   <= wb_dout[DATA_W-1:0];
                        end
                    end
                end
                S_SETUP: begin
                    sck_q <= cpol_s_q;
                    if (half_end) begin
                        // First leading edge.
                        state_q <= S_SHIFT;
                        cnt_q   <= '0;
                        sck_q   <= ~cpol_s_q;
                        if (cpha_s_q) begin
                            mosi_q <= first_bit(tx_q, lsb_s_q);
                            tx_q   <= shift_out(tx_q, lsb_s_q);
                        end else begin
                            rsh_q  <= shift_in(rsh_q, lsb_s_q, spi_miso);
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (half_end) begin
                        cnt_q <= '0;
                        if (hp_q == HP_LAST) begin
                            // SCK is already back at CPOL in the last half-period.
                            state_q <= S_HOLD;
                            sck_q   <= cpol_s_q;
                        end else begin
                            hp_q  <= hp_q + HP_W'(1);
                            sck_q <= ~sck_q;
                            if (hp_q[0]) begin
                                // Leading edge into an even half-period.
                                if (cpha_s_q) begin
                                    mosi_q <= first_bit(tx_q, lsb_s_q);
                                    tx_q   <= shift_out(tx_q, lsb_s_q);
                                end else begin
                                    rsh_q  <= shift_in(rsh_q, lsb_s_q, spi_miso);
                                end
                            end else begin
                                // Trailing edge; CPHA=0 has no bit left to present after the last one.
                                if (cpha_s_q) begin
                                    rsh_q <= shift_in(rsh_q, lsb_s_q, spi_miso);
                                end else if (hp_q != HP_PEN) begin
                                    mosi_q <= first_bit(tx_q, lsb_s_q);
                                    tx_q   <= shift_out(tx_q, lsb_s_q);
                                end
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                S_HOLD: begin
                    sck_q <= cpol_s_q;
                    if (half_end) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        rx_q    <= rsh_q;
                        if (hold_s_q) begin
                            held_q <= 1'b1;
                        end else begin
                            ss_q   <= '1;
                            held_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wb_ack   = wb_ack_q;
    assign wb_din   = wb_din_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_ss   = ss_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_wb_spi_master_mc.sv
module tb_wb_spi_master_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_addr;
    logic        wb_we, wb_stb, wb_cyc;
    logic [31:0] wb_dout;
    logic [31:0] wb_din;
    logic        wb_ack;
    logic        spi_sck, spi_mosi, spi_miso;
    logic [3:0]  spi_ss;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_flag = 1'b0;

    logic        loop_en = 1'b1;
    logic        tb_cpol = 1'b0, tb_cpha = 1'b0;

    // SCK edge monitor: counts rising edges, captures MOSI at each sampling edge.
    logic        sck_prev = 1'b0;
    int          rise_cnt = 0;
    int          nsamp    = 0;
    logic [7:0]  seq      = 8'h00;

    // M25LC020A read model (mode 0, 8-bit address).
    logic [7:0]  ee_mem [256];
    logic [7:0]  ee_in = 8'h00, ee_cmd = 8'h00, ee_out = 8'h00;
    int          ee_bits = 0;
    logic        ee_so = 1'b0, ee_sck_prev = 1'b0;
    logic        ss_watch = 1'b0, ss_bad = 1'b0;

    assign spi_miso = loop_en ? spi_mosi : ee_so;

    wb_spi_master_mc #(.DATA_W(8), .NUM_SS(4), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .wb_addr(wb_addr), .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc),
        .wb_dout(wb_dout), .wb_din(wb_din), .wb_ack(wb_ack), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_ss(spi_ss), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (spi_sck != sck_prev) begin
            if (spi_sck) rise_cnt++;
            if ((spi_sck != tb_cpol) != tb_cpha) begin
                seq = {seq[6:0], spi_mosi};
                nsamp++;
            end
        end
        sck_prev = spi_sck;
    end

    always @(negedge clk) begin
        if (spi_ss[2]) begin
            ee_bits = 0;
        end else if (spi_sck != ee_sck_prev) begin
            if (spi_sck) begin
                ee_in = {ee_in[6:0], spi_mosi};
                ee_bits++;
                if (ee_bits == 8)  ee_cmd = ee_in;
                if (ee_bits == 16) ee_out = (ee_cmd == 8'h03) ? ee_mem[ee_in] : 8'h00;
            end else if (ee_bits >= 16) begin
                ee_so  = ee_out[7];
                ee_out = {ee_out[6:0], 1'b0};
            end
        end
        ee_sck_prev = spi_sck;
        if (ss_watch && spi_ss !== 4'b1011) ss_bad = 1'b1;
    end

    // Scoreboard monitor: every read ack is compared with the oldest queued expectation.
    always @(negedge clk) begin
        if (wb_ack && rd_flag) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: got %h, nothing expected", wb_din);
            end else begin
                logic [31:0] e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (wb_din !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", nm, wb_din, e);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic [31:0] addr, input logic we, input logic [31:0] data);
        int n;
        @(negedge clk);
        rd_flag = !we;
        wb_addr = addr; wb_we = we; wb_dout = data; wb_stb = 1'b1; wb_cyc = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_ack && n < 20);
        if (!wb_ack) begin
            n_tests++;
            n_fail++;
            $display("FAIL bus_timeout: no ack for addr %h after %0d cycles", addr, n);
            if (!we && exp_q.size() > 0) begin
                void'(exp_q.pop_back());
                void'(name_q.pop_back());
            end
        end
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus(addr, 1'b1, data);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        bus(addr, 1'b0, 32'h0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, r0, s0;
        for (int i = 0; i < 256; i++) ee_mem[i] = 8'h00;
        ee_mem[8'hFE] = 8'h6B;
        rst = 1'b1; wb_addr = '0; wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0; wb_dout = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        check("rst_ss", 32'(spi_ss), 32'hF);
        check("rst_sck", 32'(spi_sck), 0);
        check("rst_mosi", 32'(spi_mosi), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_ack", 32'(wb_ack), 0);
        rd(32'h00, 32'h0, "rst_ctrl");
        rd(32'h04, 32'h0, "rst_status");
        rd(32'h20, 32'h0, "rst_div");

        // Register widths and unmapped addresses
        wr(32'h00, 32'hFFFF_FFFF);
        rd(32'h00, 32'h0000_031F, "ctrl_mask");
        wr(32'h20, 32'h0001_2345);
        rd(32'h20, 32'h0000_2345, "div_mask");
        wr(32'h44, 32'hFFFF_FFFF);
        rd(32'h44, 32'h0, "unmapped");

        // Mode 0 loopback, DIV=1 (H=2), IEN
        wr(32'h20, 32'h1);
        wr(32'h00, 32'h08);
        tb_cpol = 1'b0; tb_cpha = 1'b0;
        wait_cycles(2);
        r0 = rise_cnt; s0 = nsamp;
        wr(32'h10, 32'hA5);
        c = 0;
        do begin
            @(posedge clk); #1;
            c++;
        end while (!irq && c < 100);
        check("m0_irq_latency", c, 36);
        @(negedge clk);
        check("m0_sck_rises", rise_cnt - r0, 8);
        check("m0_mosi_seq", 32'(seq), 32'hA5);
        rd(32'h10, 32'h0000_00A5, "m0_rx");
        check("m0_irq_cleared", 32'(irq), 0);

        // Modes 1..3, LSB first
        for (int m = 1; m < 4; m++) begin
            logic [1:0] mm;
            mm = m[1:0];
            wr(32'h00, 32'(mm) | 32'h4);
            tb_cpol = mm[0]; tb_cpha = mm[1];
            wait_cycles(2);
            check($sformatf("m%0d_idle_sck", m), 32'(spi_sck), 32'(mm[0]));
            s0 = nsamp;
            wr(32'h10, 32'h3C);
            wait_cycles(40);
            check($sformatf("m%0d_sck_after", m), 32'(spi_sck), 32'(mm[0]));
            check($sformatf("m%0d_nsamp", m), nsamp - s0, 8);
            check($sformatf("m%0d_mosi_seq", m), 32'(seq), 32'h3C);
            rd(32'h10, 32'h3C, $sformatf("m%0d_rx", m));
            rd(32'h04, 32'h0, $sformatf("m%0d_status", m));
        end

        // Overrun
        wr(32'h00, 32'h0);
        tb_cpol = 1'b0; tb_cpha = 1'b0;
        wait_cycles(2);
        wr(32'h10, 32'h5A);
        wait_cycles(3);
        wr(32'h10, 32'hFF);
        rd(32'h04, 32'h5, "ovr_status");
        wr(32'h04, 32'h4);
        rd(32'h04, 32'h1, "ovr_cleared");
        wait_cycles(40);
        rd(32'h04, 32'h2, "ovr_done");
        rd(32'h10, 32'h5A, "ovr_tx_unchanged");

        // EEPROM read on SS 2 with HOLD_SS
        loop_en = 1'b0;
        wr(32'h00, 32'h210);
        wait_cycles(2);
        wr(32'h10, 32'h03);
        ss_watch = 1'b1;
        wait_cycles(40);
        wr(32'h10, 32'hFE);
        wait_cycles(40);
        wr(32'h10, 32'h00);
        wait_cycles(40);
        check("ee_ss_held", 32'(spi_ss), 32'hB);
        ss_watch = 1'b0;
        check("ee_ss_no_glitch", 32'(ss_bad), 0);
        rd(32'h10, 32'h6B, "ee_data");
        wr(32'h00, 32'h200);
        check("ee_ss_release", 32'(spi_ss), 32'hF);
        loop_en = 1'b1;

        // Reset mid-transfer, CPOL=1
        wr(32'h00, 32'h01);
        tb_cpol = 1'b1;
        wait_cycles(2);
        wr(32'h10, 32'h81);
        repeat (17) @(posedge clk);
        @(negedge clk);
        check("mid_ss_active", 32'(spi_ss), 32'hE);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ss", 32'(spi_ss), 32'hF);
        check("mid_rst_sck", 32'(spi_sck), 0);
        check("mid_rst_irq", 32'(irq), 0);
        rd(32'h04, 32'h0, "mid_rst_status");
        rd(32'h20, 32'h0, "mid_rst_div");

        wait_cycles(3);
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
